heap_controller: RTL and testbench

//  Hardware binary max-heap over an internal WIDTH x DEPTH register array; keeps element count n.
//  Ops are issued by a start/op handshake:
//   - LOAD: raw append, no ordering.
//   - MAKE: Floyd bottom-up heapify of entries [0,n).
//   - PUSH: append key, then sift up.
//   - POP:  return root, move last entry to root, then sift down.

---
 rtl/heap_controller_if.sv | 24 ++
 rtl/heap_controller.sv | 234 +++++++++++++++++++++++
 tb/tb_heap_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/heap_controller_if.sv
// Op handshake and result bundle for heap_controller.
interface heap_controller_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 10
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] key;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] pop_data;
  logic [AW:0]      n;

  modport master (
    output start, op, key,
    input  busy, done, err, pop_data, n
  );

  modport slave (
    input  start, op, key,
    output busy, done, err, pop_data, n
  );
endinterface

// File: rtl/heap_controller.sv
// Binary heap priority-queue engine over an internal register array.
// Define HEAP_MIN_EN for a min-heap build; otherwise a max-heap.
module heap_controller #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  heap_controller_if.slave bus,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  typedef enum logic [2:0] {
    IDLE, EXEC, SIFT_UP, SIFT_DOWN, BUILD, DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_MAKE = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  localparam logic [AW:0]   DEPTH_N = (AW+1)'(DEPTH);
  localparam logic [AW:0]   N_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   N_TWO   = (AW+1)'(2);
  localparam logic [AW-1:0] I_ONE   = AW'(1);

  logic [WIDTH-1:0] arr_q [DEPTH];

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic [AW:0]      n_q, n_d;
  logic [AW-1:0]    i_q, i_d;
  logic [AW-1:0]    j_q, j_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] pop_q, pop_d;

  logic             wa_en, wb_en;
  logic [AW-1:0]    wa_idx, wb_idx;
  logic [WIDTH-1:0] wa_data, wb_data;

  // True when a must sit above b in the heap.
  function automatic logic ahead(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef HEAP_MIN_EN
    return a < b;
`else
    return a > b;
`endif
  endfunction

  logic             full;
  logic [AW-1:0]    last_idx, par_idx, half_m1;
  logic [AW+1:0]    lc_w, rc_w;
  logic             lc_ok, rc_ok;
  logic [AW-1:0]    lc_idx, rc_idx, c_idx;
  logic [WIDTH-1:0] cur_v, par_v, lc_v, rc_v, c_v;
  logic             up_swap, down_swap;

  assign full     = (n_q == DEPTH_N);
  assign last_idx = AW'(n_q - N_ONE);
  assign half_m1  = AW'((n_q >> 1) - N_ONE);
  assign par_idx  = (i_q - I_ONE) >> 1;

  // Child indices carry two extra bits so 2i+2 never wraps before the bound test.
  assign lc_w   = {1'b0, i_q, 1'b1};
  assign rc_w   = lc_w + (AW+2)'(1);
  assign lc_ok  = lc_w < {1'b0, n_q};
  assign rc_ok  = rc_w < {1'b0, n_q};
  assign lc_idx = lc_w[AW-1:0];
  assign rc_idx = rc_w[AW-1:0];

  assign cur_v = arr_q[i_q];
  assign par_v = arr_q[par_idx];
  assign lc_v  = arr_q[lc_idx];
  assign rc_v  = arr_q[rc_idx];

  // Equal children resolve to the left one.
  assign c_idx = (rc_ok && ahead(rc_v, lc_v)) ? rc_idx : lc_idx;
  assign c_v   = (rc_ok && ahead(rc_v, lc_v)) ? rc_v   : lc_v;

  assign up_swap   = (i_q != '0) && ahead(cur_v, par_v);
  assign down_swap = lc_ok && ahead(c_v, cur_v);

  assign rd_data      = arr_q[rd_idx];
  assign bus.pop_data = pop_q;
  assign bus.n        = n_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (bus.start) state_d = EXEC;
      EXEC: begin
        unique case (op_q)
          OP_LOAD: state_d = DONE;
          OP_PUSH: state_d = full ? DONE : SIFT_UP;
          OP_POP:  state_d = (n_q <= N_ONE) ? DONE : SIFT_DOWN;
          OP_MAKE: state_d = (n_q < N_TWO) ? DONE : SIFT_DOWN;
        endcase
      end
      SIFT_UP:   if (!up_swap) state_d = DONE;
      SIFT_DOWN: if (!down_swap) state_d = (op_q == OP_MAKE) ? BUILD : DONE;
      BUILD:     state_d = (j_q == '0) ? DONE : SIFT_DOWN;
      // DONE has busy low, so a new request is accepted here too.
      DONE:      state_d = bus.start ? EXEC : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    key_d   = key_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    err_d   = err_q;
    pop_d   = pop_q;
    wa_en   = 1'b0;
    wa_idx  = i_q;
    wa_data = key_q;
    wb_en   = 1'b0;
    wb_idx  = i_q;
    wb_data = cur_v;

    bus.busy = state_q inside {EXEC, SIFT_UP, SIFT_DOWN, BUILD};
    bus.done = (state_q == DONE);
    bus.err  = (state_q == DONE) && err_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          op_d  = op_e'(bus.op);
          key_d = bus.key;
          err_d = 1'b0;
        end
      end
      EXEC: begin
        unique case (op_q)
          OP_LOAD, OP_PUSH: begin
            if (full) begin
              err_d = 1'b1;
            end else begin
              wa_en   = 1'b1;
              wa_idx  = AW'(n_q);
              wa_data = key_q;
              n_d     = n_q + N_ONE;
              i_d     = AW'(n_q);
            end
          end
          OP_POP: begin
            if (n_q == '0) begin
              err_d = 1'b1;
            end else begin
              pop_d   = arr_q[0];
              wa_en   = 1'b1;
              wa_idx  = '0;
              wa_data = arr_q[last_idx];
              n_d     = n_q - N_ONE;
              i_d     = '0;
            end
          end
          OP_MAKE: begin
            j_d = half_m1;
            i_d = half_m1;
          end
        endcase
      end
      SIFT_UP: begin
        if (up_swap) begin
          wa_en   = 1'b1;
          wa_idx  = i_q;
          wa_data = par_v;
          wb_en   = 1'b1;
          wb_idx  = par_idx;
          wb_data = cur_v;
          i_d     = par_idx;
        end
      end
      SIFT_DOWN: begin
        if (down_swap) begin
          wa_en   = 1'b1;
          wa_idx  = i_q;
          wa_data = c_v;
          wb_en   = 1'b1;
          wb_idx  = c_idx;
          wb_data = cur_v;
          i_d     = c_idx;
        end
      end
      BUILD: begin
        if (j_q != '0) begin
          j_d = j_q - I_ONE;
          i_d = j_q - I_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= OP_PUSH;
      key_q <= '0;
      n_q   <= '0;
      i_q   <= '0;
      j_q   <= '0;
      err_q <= 1'b0;
      pop_q <= '0;
    end else begin
      op_q  <= op_d;
      key_q <= key_d;
      n_q   <= n_d;
      i_q   <= i_d;
      j_q   <= j_d;
      err_q <= err_d;
      pop_q <= pop_d;
    end
  end

  // Storage is never cleared; reset only blocks the write of an aborted step.
  always_ff @(posedge clk) begin
    if (!reset && wa_en) arr_q[wa_idx] <= wa_data;
    if (!reset && wb_en) arr_q[wb_idx] <= wb_data;
  end

endmodule

// File: tb/tb_heap_controller.sv
// Directed self-checking bench for heap_controller (max-heap build).
module tb_heap_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_MAKE = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  heap_controller_if #(.WIDTH(32), .AW(10)) bus ();
  heap_controller_if #(.WIDTH(32), .AW(2))  bus_s ();

  logic [9:0]  rd_idx;
  logic [31:0] rd_data;
  logic [1:0]  rd_idx_s;
  logic [31:0] rd_data_s;

  int checks = 0;
  int errors = 0;

  heap_controller #(.WIDTH(32), .DEPTH(1024), .AW(10)) u_dut (
    .clk(clk), .reset(reset), .bus(bus), .rd_idx(rd_idx), .rd_data(rd_data)
  );

  heap_controller #(.WIDTH(32), .DEPTH(4), .AW(2)) u_small (
    .clk(clk), .reset(reset), .bus(bus_s), .rd_idx(rd_idx_s), .rd_data(rd_data_s)
  );

  task automatic run_op(input logic [1:0] o, input logic [31:0] k,
                        output logic e, output int cyc, output logic to);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.key = k;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1; to = 1'b1; e = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (bus.done) begin e = bus.err; to = 1'b0; break; end
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic run_op_s(input logic [1:0] o, input logic [31:0] k,
                          output logic e, output logic to);
    @(negedge clk);
    bus_s.start = 1'b1; bus_s.op = o; bus_s.key = k;
    @(posedge clk); #1;
    bus_s.start = 1'b0;
    to = 1'b1; e = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (bus_s.done) begin e = bus_s.err; to = 1'b0; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic e, to; int cyc;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.n !== 11'd0) begin errors++; $display("FAIL reset_n: got %0d expected 0", bus.n); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.pop_data !== 32'd0) begin errors++; $display("FAIL reset_pop_data: got %0d expected 0", bus.pop_data); end
    reset = 1'b0;
    run_op(OP_POP, 32'd0, e, cyc, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL empty_pop_timeout: got %b expected 0", to); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL empty_pop_err: got %b expected 1", e); end
    checks++; if (bus.pop_data !== 32'd0) begin errors++; $display("FAIL empty_pop_data: got %0d expected 0", bus.pop_data); end
  endtask

  task automatic test_load_make();
    logic e, to; int cyc;
    logic [31:0] vals [10] = '{10, 20, 5, 6, 1, 8, 9, 4, 7, 2};
    logic [31:0] exp_a [10] = '{20, 10, 9, 7, 2, 8, 5, 4, 6, 1};
    for (int k = 0; k < 10; k++) begin
      run_op(OP_LOAD, vals[k], e, cyc, to);
      checks++; if (to !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL load_%0d: timeout %b err %b expected 0 0", k, to, e); end
      if (k == 0) begin
        checks++; if (cyc != 2) begin errors++; $display("FAIL load_latency: got %0d expected 2", cyc); end
      end
    end
    checks++; if (bus.n !== 11'd10) begin errors++; $display("FAIL load_n: got %0d expected 10", bus.n); end
    run_op(OP_MAKE, 32'd0, e, cyc, to);
    checks++; if (to !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL make: timeout %b err %b expected 0 0", to, e); end
    checks++; if (bus.n !== 11'd10) begin errors++; $display("FAIL make_n: got %0d expected 10", bus.n); end
    for (int k = 0; k < 10; k++) begin
      rd_idx = 10'(k); #1;
      checks++; if (rd_data !== exp_a[k]) begin errors++; $display("FAIL make_arr[%0d]: got %0d expected %0d", k, rd_data, exp_a[k]); end
    end
  endtask

  task automatic test_push();
    logic e, to; int cyc;
    logic [31:0] exp_a [11] = '{20, 15, 9, 7, 10, 8, 5, 4, 6, 1, 2};
    run_op(OP_PUSH, 32'd15, e, cyc, to);
    checks++; if (to !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL push: timeout %b err %b expected 0 0", to, e); end
    checks++; if (cyc > 6) begin errors++; $display("FAIL push_latency: got %0d expected <= 6", cyc); end
    checks++; if (bus.n !== 11'd11) begin errors++; $display("FAIL push_n: got %0d expected 11", bus.n); end
    for (int k = 0; k < 11; k++) begin
      rd_idx = 10'(k); #1;
      checks++; if (rd_data !== exp_a[k]) begin errors++; $display("FAIL push_arr[%0d]: got %0d expected %0d", k, rd_data, exp_a[k]); end
    end
  endtask

  task automatic test_pop();
    logic e, to; int cyc;
    logic [31:0] exp_a [10] = '{15, 10, 9, 7, 2, 8, 5, 4, 6, 1};
    run_op(OP_POP, 32'd0, e, cyc, to);
    checks++; if (to !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL pop: timeout %b err %b expected 0 0", to, e); end
    checks++; if (bus.pop_data !== 32'd20) begin errors++; $display("FAIL pop_data: got %0d expected 20", bus.pop_data); end
    checks++; if (bus.n !== 11'd10) begin errors++; $display("FAIL pop_n: got %0d expected 10", bus.n); end
    for (int k = 0; k < 10; k++) begin
      rd_idx = 10'(k); #1;
      checks++; if (rd_data !== exp_a[k]) begin errors++; $display("FAIL pop_arr[%0d]: got %0d expected %0d", k, rd_data, exp_a[k]); end
    end
  endtask

  task automatic test_full();
    logic e, to;
    logic [31:0] vals [4] = '{3, 1, 4, 2};
    for (int k = 0; k < 4; k++) begin
      run_op_s(OP_LOAD, vals[k], e, to);
      checks++; if (to !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL fill_%0d: timeout %b err %b expected 0 0", k, to, e); end
    end
    checks++; if (bus_s.n !== 3'd4) begin errors++; $display("FAIL fill_n: got %0d expected 4", bus_s.n); end
    run_op_s(OP_PUSH, 32'd99, e, to);
    checks++; if (to !== 1'b0 || e !== 1'b1) begin errors++; $display("FAIL full_push: timeout %b err %b expected 0 1", to, e); end
    checks++; if (bus_s.n !== 3'd4) begin errors++; $display("FAIL full_push_n: got %0d expected 4", bus_s.n); end
    run_op_s(OP_LOAD, 32'd77, e, to);
    checks++; if (to !== 1'b0 || e !== 1'b1) begin errors++; $display("FAIL full_load: timeout %b err %b expected 0 1", to, e); end
    for (int k = 0; k < 4; k++) begin
      rd_idx_s = 2'(k); #1;
      checks++; if (rd_data_s !== vals[k]) begin errors++; $display("FAIL full_arr[%0d]: got %0d expected %0d", k, rd_data_s, vals[k]); end
    end
  endtask

  task automatic test_reset_mid_make();
    logic e, to, seen_done; int cyc;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      run_op(OP_LOAD, 32'(k), e, cyc, to);
      checks++; if (to !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL ramp_load_%0d: timeout %b err %b expected 0 0", k, to, e); end
    end
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MAKE; bus.key = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL make_in_progress: busy %b expected 1", bus.busy); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.n !== 11'd0) begin errors++; $display("FAIL abort_n: got %0d expected 0", bus.n); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", bus.done); end
    @(negedge clk); reset = 1'b0;
    seen_done = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_late_done: got %b expected 0", seen_done); end
    run_op(OP_LOAD, 32'd7, e, cyc, to);
    checks++; if (to !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL reload: timeout %b err %b expected 0 0", to, e); end
    checks++; if (bus.n !== 11'd1) begin errors++; $display("FAIL reload_n: got %0d expected 1", bus.n); end
    rd_idx = 10'd0; #1;
    checks++; if (rd_data !== 32'd7) begin errors++; $display("FAIL reload_arr0: got %0d expected 7", rd_data); end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.key = '0;
    bus_s.start = 1'b0; bus_s.op = 2'b00; bus_s.key = '0;
    rd_idx = '0; rd_idx_s = '0;
    test_reset();
    test_load_make();
    test_push();
    test_pop();
    test_full();
    test_reset_mid_make();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
